// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: launches one CPU program run.
// It writes operands A and B into data memory, holds Start, waits for Ack
// (with a timeout), reads the result back and reports Pass/TimedOut/Cycles.
// Every output comes straight from a flop. Outputs are decoded from the next
// state, so they are valid during the cycle the FSM spends in that state.
module cpu_run_sequencer #(
   parameter logic [7:0]  ADDR_A     = 8'd1,
   parameter logic [7:0]  ADDR_B     = 8'd2,
   parameter logic [7:0]  ADDR_R     = 8'd3,
   parameter int          START_HOLD = 2,
   parameter logic [15:0] TIMEOUT    = 16'd4000
) (
   input  logic        Clk_i,
   input  logic        Reset_i,
   input  logic        Go_i,
   input  logic [7:0]  OpA_i,
   input  logic [7:0]  OpB_i,
   input  logic [7:0]  Expected_i,
   input  logic        Ack_i,
   input  logic [7:0]  MemDataIn_i,
   output logic        Start_o,
   output logic [7:0]  MemAddr_o,
   output logic        MemWrite_o,
   output logic [7:0]  MemDataOut_o,
   output logic        Busy_o,
   output logic        Done_o,
   output logic        Pass_o,
   output logic        TimedOut_o,
   output logic [7:0]  Result_o,
   output logic [15:0] Cycles_o
);

   typedef enum logic [2:0] {
      IDLE, WR_A, WR_B, HOLD, WAIT_ACK, RD_ADDR, RD_DATA, REPORT
   } state_t;

   state_t      state_q, state_d;
   logic        armed_q, armed_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic [7:0]  op_a_q, op_a_d;
   logic [7:0]  op_b_q, op_b_d;
   logic [7:0]  expected_q, expected_d;
   logic        start_q, start_d;
   logic [7:0]  mem_addr_q, mem_addr_d;
   logic        mem_write_q, mem_write_d;
   logic [7:0]  mem_data_out_q, mem_data_out_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        timed_out_q, timed_out_d;
   logic [7:0]  result_q, result_d;
   logic [15:0] cycles_q, cycles_d;

   // State, captured operands and registered outputs; reset forces everything idle.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q        <= IDLE;
         armed_q        <= 1'b0;
         hold_cnt_q     <= 4'd0;
         op_a_q         <= 8'd0;
         op_b_q         <= 8'd0;
         expected_q     <= 8'd0;
         start_q        <= 1'b0;
         mem_addr_q     <= 8'd0;
         mem_write_q    <= 1'b0;
         mem_data_out_q <= 8'd0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         timed_out_q    <= 1'b0;
         result_q       <= 8'd0;
         cycles_q       <= 16'd0;
      end else begin
         state_q        <= state_d;
         armed_q        <= armed_d;
         hold_cnt_q     <= hold_cnt_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         expected_q     <= expected_d;
         start_q        <= start_d;
         mem_addr_q     <= mem_addr_d;
         mem_write_q    <= mem_write_d;
         mem_data_out_q <= mem_data_out_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         timed_out_q    <= timed_out_d;
         result_q       <= result_d;
         cycles_q       <= cycles_d;
      end
   end

   // Next-state logic plus output decode from the next state.
   always_comb begin
      state_d        = state_q;
      // armed_q stays low for the first edge after reset release so a Go
      // present while Reset falls is not taken as a launch request.
      armed_d        = 1'b1;
      hold_cnt_d     = hold_cnt_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      expected_d     = expected_q;
      busy_d         = busy_q;
      done_d         = done_q;
      pass_d         = pass_q;
      timed_out_d    = timed_out_q;
      result_d       = result_q;
      cycles_d       = cycles_q;
      start_d        = 1'b0;
      mem_addr_d     = 8'd0;
      mem_write_d    = 1'b0;
      mem_data_out_d = 8'd0;

      case (state_q)
         IDLE, REPORT: begin
            if (Go_i && armed_q) begin
               state_d     = WR_A;
               op_a_d      = OpA_i;
               op_b_d      = OpB_i;
               expected_d  = Expected_i;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               timed_out_d = 1'b0;
               cycles_d    = 16'd0;
            end
         end
         WR_A: state_d = WR_B;
         WR_B: begin
            state_d    = HOLD;
            hold_cnt_d = 4'd0;
         end
         HOLD: begin
            if (hold_cnt_q == 4'(START_HOLD - 1)) begin
               state_d = WAIT_ACK;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end
         WAIT_ACK: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (Ack_i) begin
               state_d = RD_ADDR;
            end else begin
               cycles_d = cycles_q + 16'd1;
               if (cycles_d == TIMEOUT) begin
                  state_d     = REPORT;
                  timed_out_d = 1'b1;
                  pass_d      = 1'b0;
                  result_d    = 8'd0;
                  done_d      = 1'b1;
                  busy_d      = 1'b0;
               end
            end
         end
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            state_d  = REPORT;
            result_d = MemDataIn_i;
            pass_d   = (MemDataIn_i == expected_q);
            done_d   = 1'b1;
            busy_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         WR_A: begin
            start_d        = 1'b1;
            mem_addr_d     = ADDR_A;
            mem_write_d    = 1'b1;
            mem_data_out_d = op_a_d;
         end
         WR_B: begin
            start_d        = 1'b1;
            mem_addr_d     = ADDR_B;
            mem_write_d    = 1'b1;
            mem_data_out_d = op_b_d;
         end
         HOLD:             start_d    = 1'b1;
         RD_ADDR, RD_DATA: mem_addr_d = ADDR_R;
         default:          start_d    = 1'b0;
      endcase
   end

   assign Start_o      = start_q;
   assign MemAddr_o    = mem_addr_q;
   assign MemWrite_o   = mem_write_q;
   assign MemDataOut_o = mem_data_out_q;
   assign Busy_o       = busy_q;
   assign Done_o       = done_q;
   assign Pass_o       = pass_q;
   assign TimedOut_o   = timed_out_q;
   assign Result_o     = result_q;
   assign Cycles_o     = cycles_q;

endmodule
